// File: rtl/dac_mode_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_sched_pkg
// Brief    : Mode encoding and command record shared by the DAC mode scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dac_sched_pkg;

    localparam int c_num_ch   = 4;
    localparam int c_ts_width = 64;
    localparam int c_ch_width = $clog2(c_num_ch);

    localparam logic [1:0] c_mode_dds    = 2'd0;
    localparam logic [1:0] c_mode_direct = 2'd1;
    localparam logic [1:0] c_mode_mute   = 2'd2;
    localparam logic [1:0] c_mode_rsvd   = 2'd3;

    typedef enum logic [1:0] {
        DAC_DDS    = c_mode_dds,
        DAC_DIRECT = c_mode_direct,
        DAC_MUTE   = c_mode_mute,
        DAC_RSVD   = c_mode_rsvd
    } dac_mode_e;

    typedef struct packed {
        logic [c_ts_width-1:0] timestamp;
        logic [c_ch_width-1:0] channel;
        dac_mode_e             mode;
    } dac_cmd_t;

endpackage
`default_nettype wire

// File: rtl/dac_mode_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_mode_scheduler_if
// Brief    : Timestamped command push channel (valid/ready) into the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_mode_scheduler_if;
    import dac_sched_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [c_ts_width-1:0] cmd_timestamp;
    logic [c_ch_width-1:0] cmd_channel;
    logic [1:0]            cmd_mode;

    modport master (
        output cmd_valid, cmd_timestamp, cmd_channel, cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_timestamp, cmd_channel, cmd_mode,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/dac_mode_scheduler_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dac_cmd_fifo
// Brief    : Synchronous command FIFO with flush and fall-through head output.
// Revision : 1.0 - initial release
// ============================================================================
module dac_cmd_fifo
    import dac_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_flush,
    input  wire logic     i_push,
    input  var  dac_cmd_t i_push_data,
    input  wire logic     i_pop,
    output dac_cmd_t      o_head,
    output logic          o_full,
    output logic          o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    dac_cmd_t        r_mem [DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dac_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dac_mode_scheduler
// Brief    : Timestamp-driven per-channel DAC source select (DDS/direct/mute).
// Revision : 1.0 - initial release
// ============================================================================
module dac_mode_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_CH       = c_num_ch,
    parameter int SAMPLE_WIDTH = 256,
    parameter int CMD_DEPTH    = 16,
    parameter int TS_WIDTH     = c_ts_width
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic [TS_WIDTH-1:0]            counter,
    dac_mode_scheduler_if.slave                 cmd,
    input  wire logic                           flush,
    input  wire logic                           clear_error,
    input  wire logic [NUM_CH*SAMPLE_WIDTH-1:0] dds_tdata,
    input  wire logic [NUM_CH-1:0]              dds_tvalid,
    input  wire logic [NUM_CH*SAMPLE_WIDTH-1:0] direct_tdata,
    input  wire logic [NUM_CH-1:0]              direct_tvalid,
    output logic      [NUM_CH*SAMPLE_WIDTH-1:0] m_axis_tdata,
    output logic      [NUM_CH-1:0]              m_axis_tvalid,
    input  wire logic [NUM_CH-1:0]              m_axis_tready,
    output logic      [2*NUM_CH-1:0]            mode_out,
    output logic                                fifo_full,
    output logic                                fifo_empty,
    output logic                                late_error,
    output logic                                mode_error
);
    dac_cmd_t  w_push_cmd;
    dac_cmd_t  w_head;
    dac_mode_e w_new_mode;
    dac_mode_e r_mode [NUM_CH];
    logic      w_exec;
    logic      w_late;
    logic      w_rsvd;
    logic      r_late_err;
    logic      r_mode_err;

    assign w_push_cmd    = '{timestamp: cmd.cmd_timestamp,
                             channel:   cmd.cmd_channel,
                             mode:      dac_mode_e'(cmd.cmd_mode)};
    assign cmd.cmd_ready = !fifo_full;

    dac_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (flush),
        .i_push      (cmd.cmd_valid),
        .i_push_data (w_push_cmd),
        .i_pop       (w_exec),
        .o_head      (w_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign w_exec     = !fifo_empty && (counter >= w_head.timestamp);
    assign w_late     = counter > w_head.timestamp;
    assign w_rsvd     = (w_head.mode == DAC_RSVD);
    assign w_new_mode = w_rsvd ? DAC_MUTE : w_head.mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_mode[i] <= DAC_DDS;
        end else if (w_exec) begin
            r_mode[w_head.channel] <= w_new_mode;
        end
    end

    // A new error event on the same edge as clear_error keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_late_err <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            if (w_exec && w_late) r_late_err <= 1'b1;
            else if (clear_error) r_late_err <= 1'b0;
            if (w_exec && w_rsvd) r_mode_err <= 1'b1;
            else if (clear_error) r_mode_err <= 1'b0;
        end
    end

    assign late_error = r_late_err;
    assign mode_error = r_mode_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SAMPLE_WIDTH-1:0] r_tdata;
        logic                    r_tvalid;
        logic                    w_load;

        assign w_load = !r_tvalid || m_axis_tready[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_tdata  <= '0;
                r_tvalid <= 1'b0;
            end else if (w_load) begin
                case (r_mode[gi])
                    DAC_DDS: begin
                        r_tdata  <= dds_tdata[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        r_tvalid <= dds_tvalid[gi];
                    end
                    DAC_DIRECT: begin
                        r_tdata  <= direct_tdata[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        r_tvalid <= direct_tvalid[gi];
                    end
                    default: begin
                        r_tdata  <= '0;
                        r_tvalid <= 1'b1;
                    end
                endcase
            end
        end

        assign m_axis_tdata[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_tdata;
        assign m_axis_tvalid[gi]                             = r_tvalid;
        assign mode_out[2*gi +: 2]                           = r_mode[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_mode_scheduler
// Brief    : Directed bench with a queue-level reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_mode_scheduler;
    localparam int c_nch   = 4;
    localparam int c_sw    = 256;
    localparam int c_depth = 16;

    typedef struct {
        logic [63:0] ts;
        logic [1:0]  ch;
        logic [1:0]  mode;
    } mcmd_t;

    logic                   clk;
    logic                   reset;
    logic [63:0]            counter;
    logic                   flush;
    logic                   clear_error;
    logic [c_nch*c_sw-1:0]  dds_tdata;
    logic [c_nch-1:0]       dds_tvalid;
    logic [c_nch*c_sw-1:0]  direct_tdata;
    logic [c_nch-1:0]       direct_tvalid;
    logic [c_nch*c_sw-1:0]  m_axis_tdata;
    logic [c_nch-1:0]       m_axis_tvalid;
    logic [c_nch-1:0]       m_axis_tready;
    logic [2*c_nch-1:0]     mode_out;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   late_error;
    logic                   mode_error;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    mcmd_t       q[$];
    logic [1:0]  m_mode  [c_nch];
    logic [255:0] m_data [c_nch];
    logic        m_valid [c_nch];
    logic        m_late;
    logic        m_merr;

    dac_mode_scheduler_if cmd_if ();

    dac_mode_scheduler #(
        .NUM_CH       (c_nch),
        .SAMPLE_WIDTH (c_sw),
        .CMD_DEPTH    (c_depth),
        .TS_WIDTH     (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .counter       (counter),
        .cmd           (cmd_if),
        .flush         (flush),
        .clear_error   (clear_error),
        .dds_tdata     (dds_tdata),
        .dds_tvalid    (dds_tvalid),
        .direct_tdata  (direct_tdata),
        .direct_tvalid (direct_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .mode_out      (mode_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .late_error    (late_error),
        .mode_error    (mode_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Reference model: a command queue, per-channel mode and output register.
    always @(posedge clk) begin : p_model
        mcmd_t c;
        bit    ready;
        if (reset) begin
            q.delete();
            for (int i = 0; i < c_nch; i++) begin
                m_mode[i] = 2'd0; m_data[i] = '0; m_valid[i] = 1'b0;
            end
            m_late = 1'b0;
            m_merr = 1'b0;
        end else begin
            for (int i = 0; i < c_nch; i++) begin
                if (!m_valid[i] || m_axis_tready[i]) begin
                    if (m_mode[i] == 2'd0) begin
                        m_data[i] = dds_tdata[i*c_sw +: c_sw]; m_valid[i] = dds_tvalid[i];
                    end else if (m_mode[i] == 2'd1) begin
                        m_data[i] = direct_tdata[i*c_sw +: c_sw]; m_valid[i] = direct_tvalid[i];
                    end else begin
                        m_data[i] = '0; m_valid[i] = 1'b1;
                    end
                end
            end
            ready = (q.size() < c_depth);
            if (clear_error) begin
                m_late = 1'b0;
                m_merr = 1'b0;
            end
            if (q.size() > 0 && counter >= q[0].ts) begin
                c = q.pop_front();
                m_mode[c.ch] = (c.mode == 2'd3) ? 2'd2 : c.mode;
                if (counter > c.ts)   m_late = 1'b1;
                if (c.mode == 2'd3)   m_merr = 1'b1;
            end
            if (flush) q.delete();
            else if (cmd_if.cmd_valid && ready)
                q.push_back('{cmd_if.cmd_timestamp, cmd_if.cmd_channel, cmd_if.cmd_mode});
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic [7:0] exp_mode;
        for (int i = 0; i < c_nch; i++) exp_mode[2*i +: 2] = m_mode[i];
        chk("cyc_mode_out",   mode_out,   exp_mode);
        chk("cyc_fifo_empty", fifo_empty, q.size() == 0);
        chk("cyc_fifo_full",  fifo_full,  q.size() == c_depth);
        chk("cyc_cmd_ready",  cmd_if.cmd_ready, q.size() < c_depth);
        chk("cyc_late_error", late_error, m_late);
        chk("cyc_mode_error", mode_error, m_merr);
        for (int i = 0; i < c_nch; i++) begin
            chk($sformatf("cyc_tdata%0d", i),  m_axis_tdata[i*c_sw +: c_sw], m_data[i]);
            chk($sformatf("cyc_tvalid%0d", i), m_axis_tvalid[i], m_valid[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) model_compare();
    endtask

    task automatic push(input logic [63:0] ts, input logic [1:0] ch, input logic [1:0] mode);
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_timestamp = ts;
        cmd_if.cmd_channel   = ch;
        cmd_if.cmd_mode      = mode;
        tick();
        cmd_if.cmd_valid     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; counter = '0; flush = 1'b0; clear_error = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_timestamp = '0;
        cmd_if.cmd_channel = '0; cmd_if.cmd_mode = '0;
        m_axis_tready = '1; dds_tvalid = '1; direct_tvalid = '1;
        for (int i = 0; i < c_nch; i++) begin
            dds_tdata[i*c_sw +: c_sw]    = pat(8'(8'hAA + 17 * i));
            direct_tdata[i*c_sw +: c_sw] = pat(8'(17 * (i + 1)));
        end

        tick();
        chk_en = 1;
        tick();
        chk("rst_fifo_empty", fifo_empty, 1'b1);
        chk("rst_fifo_full",  fifo_full,  1'b0);
        chk("rst_cmd_ready",  cmd_if.cmd_ready, 1'b1);
        chk("rst_mode_out",   mode_out, 8'h00);
        chk("rst_tvalid",     m_axis_tvalid, 4'h0);
        reset = 1'b0;

        tick();
        chk("dds_ch0_tdata",  m_axis_tdata[0 +: c_sw], pat(8'hAA));
        chk("dds_ch0_tvalid", m_axis_tvalid[0], 1'b1);

        counter = 64'd90;
        push(64'd100, 2'd2, 2'd1);
        for (int c = 91; c <= 100; c++) begin
            if (c == 100) chk("ontime_before", mode_out, 8'h00);
            counter = 64'(c);
            tick();
        end
        chk("ontime_mode",  mode_out, 8'h10);
        chk("ontime_late",  late_error, 1'b0);
        tick();
        chk("ontime_ch2_direct", m_axis_tdata[2*c_sw +: c_sw], pat(8'h33));

        counter = 64'd60;
        push(64'd50, 2'd0, 2'd2);
        tick();
        chk("late_set",  late_error, 1'b1);
        chk("late_mode", mode_out, 8'h12);
        tick();
        chk("mute_tdata",  m_axis_tdata[0 +: c_sw], 256'd0);
        chk("mute_tvalid", m_axis_tvalid[0], 1'b1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        chk("late_clear", late_error, 1'b0);

        counter = 64'd200;
        for (int i = 0; i < c_depth; i++) push(64'd1000, 2'(i % 4), 2'(i % 3));
        chk("fill_full",  fifo_full, 1'b1);
        chk("fill_ready", cmd_if.cmd_ready, 1'b0);
        push(64'd1000, 2'd1, 2'd3);
        chk("fill_17th_dropped", fifo_full, 1'b1);
        counter = 64'd1000;
        push(64'd2000, 2'd3, 2'd1);
        chk("full_pop_ready", cmd_if.cmd_ready, 1'b1);
        for (int i = 0; i < c_depth - 1; i++) tick();
        chk("drain_empty", fifo_empty, 1'b1);
        chk("drain_modes", mode_out, 8'h24);

        direct_tdata[1*c_sw +: c_sw] = pat(8'h50);
        m_axis_tready[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold", m_axis_tdata[1*c_sw +: c_sw], pat(8'h22));
            direct_tdata[1*c_sw +: c_sw] = pat(8'(8'h51 + k));
        end
        m_axis_tready[1] = 1'b1;
        tick();
        chk("stall_release", m_axis_tdata[1*c_sw +: c_sw], pat(8'h55));
        direct_tdata[1*c_sw +: c_sw] = pat(8'h22);

        push(64'd1000, 2'd3, 2'd3);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        chk("rsvd_mode",  mode_out, 8'hA4);
        chk("rsvd_error", mode_error, 1'b1);
        chk("rsvd_late",  late_error, 1'b0);

        for (int i = 0; i < 4; i++) push(64'd5000, 2'(i), 2'd1);
        flush = 1'b1;
        push(64'd5000, 2'd0, 2'd2);
        flush = 1'b0;
        chk("flush_empty", fifo_empty, 1'b1);
        chk("flush_modes", mode_out, 8'hA4);
        tick();
        chk("flush_push_dropped", fifo_empty, 1'b1);

        push(64'd3000, 2'd0, 2'd2);
        push(64'd3000, 2'd1, 2'd0);
        counter = 64'd3000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_exec_mode",  mode_out, 8'hA6);
        chk("flush_exec_empty", fifo_empty, 1'b1);

        push(64'd9999, 2'd2, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_empty",  fifo_empty, 1'b1);
        chk("midrst_mode",   mode_out, 8'h00);
        chk("midrst_tvalid", m_axis_tvalid, 4'h0);
        chk("midrst_merr",   mode_error, 1'b0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_mode_scheduler.md
Name: dac_mode_scheduler

Overview:
- Parametrised successor of the single-channel DAC mode mux.
- Drives NUM_CH RFDC DAC AXI-Stream channels. Each channel's source (DDS, direct sample write, or mute) is switched at a timestamp taken from a command queue.
- Sits between the per-channel DDS/direct sample generators and the RFDC DAC tiles.
- Runs on the RTO clock and compares against the shared 64-bit TimeController counter.

Parameters:
- NUM_CH, 4, number of DAC channels.
- SAMPLE_WIDTH, 256, AXIS tdata width per channel.
- CMD_DEPTH, 16, command FIFO depth (power of two, >=2).
- TS_WIDTH, 64, timestamp/counter width.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- counter  in  TS_WIDTH  TimeController counter, unsigned.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_timestamp  in  TS_WIDTH  execution time.
- cmd_channel  in  $clog2(NUM_CH)  target channel.
- cmd_mode  in  2  0=DDS, 1=direct, 2=mute, 3=reserved.
- flush  in  1  empties command FIFO.
- clear_error  in  1  clears sticky errors.
- dds_tdata  in  NUM_CH*SAMPLE_WIDTH  DDS samples, channel i at slice i.
- dds_tvalid  in  NUM_CH  DDS valid.
- direct_tdata  in  NUM_CH*SAMPLE_WIDTH  direct samples.
- direct_tvalid  in  NUM_CH  direct valid.
- m_axis_tdata  out  NUM_CH*SAMPLE_WIDTH  to RFDC.
- m_axis_tvalid  out  NUM_CH  to RFDC.
- m_axis_tready  in  NUM_CH  from RFDC.
- mode_out  out  2*NUM_CH  current mode per channel.
- fifo_full  out  1  command FIFO full.
- fifo_empty  out  1  command FIFO empty.
- late_error  out  1  sticky: a command executed after its timestamp.
- mode_error  out  1  sticky: a reserved mode was executed.

Behaviour:
- Reset:
  - FIFO empty, so fifo_empty=1, fifo_full=0, cmd_ready=1.
  - All modes = DDS (0).
  - m_axis_tdata=0, m_axis_tvalid=0.
  - late_error=0, mode_error=0.
  - Reset asserted mid-operation discards queued commands and any held output samples.
- Push:
  - cmd_ready = !fifo_full.
  - On cmd_valid && cmd_ready, {timestamp, channel, mode} is written at the tail.
- Execute:
  - Condition: !fifo_empty && counter >= head.timestamp (unsigned compare, no wrap handling).
  - On the next edge: mode[head.channel] <= head.mode, head is popped.
  - At most one command executes per cycle; commands execute strictly in FIFO order.
  - A later-timestamped head blocks every entry behind it.
- Late: if counter > head.timestamp at execution, late_error is set on the same edge.
- Reserved mode: mode 3 is stored as mute (2) and sets mode_error.
- Simultaneous push and pop:
  - Not full: both occur, occupancy unchanged.
  - Full: push refused, pop proceeds, cmd_ready rises the next cycle.
  - Empty: the new entry is not eligible to execute until the following cycle (no bypass).
- Flush:
  - FIFO emptied on the next edge.
  - Modes and output registers are untouched.
  - A push in the same cycle is dropped.
  - An execute in the same cycle still applies.
- Errors:
  - clear_error zeroes both sticky flags on the next edge.
  - If a set and a clear coincide, set wins.
- Output stage, per channel i, as an independent register slice:
  - The slice loads when !m_axis_tvalid[i] || m_axis_tready[i].
  - DDS: loads dds_tdata[i] / dds_tvalid[i].
  - Direct: loads direct_tdata[i] / direct_tvalid[i].
  - Mute: loads tdata=0, tvalid=1.
  - When not loading, tdata and tvalid hold (AXIS stability rule).
- Latency:
  - Input sample to m_axis = 1 cycle.
  - Mode register to first sample from the new source = 1 cycle, i.e. 2 cycles after counter reaches the timestamp.
  - mode_out reflects the mode register directly.
- Unselected inputs are ignored; there is no back-pressure to the sources.

Decomposition:
- Package dac_sched_pkg:
  - dac_mode_e enum (DDS, DIRECT, MUTE, RSVD).
  - dac_cmd_t struct {timestamp, channel, mode} parameterised through localparams.
  - Mode encoding constants.
- Sub-module dac_cmd_fifo: synchronous FIFO of dac_cmd_t with flush, full/empty and first-word-fall-through head.
- The top-level module holds the execute logic, mode registers and NUM_CH output slices in a generate loop.

Test Plan:
- Reset, then ready-high, 1 ch: dds_tvalid=1, dds_tdata=0xAA.. -> m_axis_tdata=0xAA.. one cycle later, mode_out=0.
- Push {ts=100, ch=2, mode=1} with counter at 90: mode_out[5:4] changes to 1 on the edge after counter=100. Channel 2 shows direct data from the next cycle; late_error stays 0.
- Push {ts=50, ch=0, mode=2} with counter already 60: executes the next eligible cycle, late_error=1, ch0 outputs tdata=0/tvalid=1. clear_error then gives late_error=0.
- Fill 16 commands with ts=1000: fifo_full=1, cmd_ready=0, a 17th push is dropped. At counter=1000 one pop per cycle; fifo_empty after 16 cycles with modes applied in order.
- m_axis_tready[1]=0 for 5 cycles while the ch1 source changes: m_axis_tdata[1] holds its value. On tready=1 the next captured sample appears; no samples are duplicated downstream.
- Push mode=3 to ch3 -> mode_out ch3=2, mode_error=1. Flush with 4 queued entries -> fifo_empty=1 the next cycle, modes unchanged.
